// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Define FIFO_STATUS_EN to add the count, overflow and underflow status ports.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  signal_write,
    input  logic                  signal_read,
`ifdef FIFO_STATUS_EN
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr, rptr;
    logic                  wr_en, rd_en;

    // Extra MSB on each pointer tells a full ring apart from an empty one.
    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                   (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);

    assign wr_en = signal_write && !full;
    assign rd_en = signal_read && !empty;

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr[ADDR_WIDTH-1:0]] <= write_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            read_data <= '0;
        end else begin
            if (wr_en)
                wptr <= wptr + 1'b1;
            if (rd_en) begin
                read_data <= mem[rptr[ADDR_WIDTH-1:0]];
                rptr      <= rptr + 1'b1;
            end
        end
    end

`ifdef FIFO_STATUS_EN
    assign count = wptr - rptr;

    // Sticky until reset so a rejected strobe is never missed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (signal_write && full)
                overflow <= 1'b1;
            if (signal_read && empty)
                underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo; covers reset, wrap, full/empty edges and async reset.
module tb_sync_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] write_data = '0;
    logic       signal_write = 1'b0;
    logic       signal_read = 1'b0;
    logic [7:0] read_data;
    logic       full, empty;
`ifdef FIFO_STATUS_EN
    logic [3:0] count;
    logic       overflow, underflow;
`endif

    int checks = 0;
    int errors = 0;

    sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .write_data   (write_data),
        .signal_write (signal_write),
        .signal_read  (signal_read),
`ifdef FIFO_STATUS_EN
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .read_data    (read_data),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1ns after the edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rdata", read_data, 0);
        tick();
        tick();
        rst = 1'b0;

        // Read while empty is ignored
        signal_read = 1'b1;
        tick();
        signal_read = 1'b0;
        chk("uf_rdata", read_data, 0);
        chk("uf_empty", empty, 1);
`ifdef FIFO_STATUS_EN
        chk("uf_flag", underflow, 1);
        chk("uf_count", count, 0);
`endif

        // Single write then read
        write_data = 8'd1; signal_write = 1'b1;
        tick();
        signal_write = 1'b0;
        chk("w1_empty", empty, 0);
        signal_read = 1'b1;
        tick();
        signal_read = 1'b0;
        chk("r1_data", read_data, 1);
        chk("r1_empty", empty, 1);

        // Simultaneous traffic across pointer wrap
        signal_write = 1'b1;
        write_data = 8'd2; tick();
        write_data = 8'd3; tick();
        signal_read = 1'b1;
        for (int k = 0; k < 9; k++) begin
            write_data = 8'(k + 4);
            tick();
            chk($sformatf("wrap_rd%0d", k), read_data, k + 2);
            chk($sformatf("wrap_full%0d", k), full, 0);
        end
        signal_write = 1'b0;
        tick();
        chk("drain_11", read_data, 11);
        tick();
        chk("drain_12", read_data, 12);
        signal_read = 1'b0;
        chk("drain_empty", empty, 1);

        // Fill to full
        signal_write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            write_data = 8'(24 + i);
            tick();
            if (i == 6) chk("fill7_full", full, 0);
        end
        chk("fill8_full", full, 1);
`ifdef FIFO_STATUS_EN
        chk("fill8_count", count, 8);
        chk("fill8_ovf", overflow, 0);
`endif
        write_data = 8'd99;
        tick();
        chk("ovf_full", full, 1);
        chk("ovf_rdata", read_data, 12);
`ifdef FIFO_STATUS_EN
        chk("ovf_flag", overflow, 1);
`endif

        // Read + write while full: read wins, write dropped
        write_data = 8'd77; signal_read = 1'b1;
        tick();
        signal_write = 1'b0;
        chk("fullrw_data", read_data, 24);
        chk("fullrw_full", full, 0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("drainf_rd%0d", i), read_data, 24 + i);
        end
        signal_read = 1'b0;
        chk("drainf_empty", empty, 1);
        tick();
        chk("drainf_hold", read_data, 31);

        // Async reset with 5 entries stored
        signal_write = 1'b1;
        for (int i = 0; i < 5; i++) begin
            write_data = 8'(40 + i);
            tick();
        end
        signal_write = 1'b0;
        chk("pre_rst_empty", empty, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_rdata", read_data, 0);
`ifdef FIFO_STATUS_EN
        chk("arst_ovf", overflow, 0);
        chk("arst_count", count, 0);
`endif
        #1 rst = 1'b0;
        tick();
        write_data = 8'd7; signal_write = 1'b1;
        tick();
        signal_write = 1'b0; signal_read = 1'b1;
        tick();
        signal_read = 1'b0;
        chk("post_rst_data", read_data, 7);
        chk("post_rst_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
